// File: rtl/moving_average_filter_if.sv
// moving_average_filter_if: sample strobe/data in, filtered data and status pulses out.
interface moving_average_filter_if #(
   parameter int WIDTH         = 16,
   parameter int CHANNELS      = 2,
   parameter int LOG_DEPTH_MAX = 3
);
   localparam int SW_W = $clog2(LOG_DEPTH_MAX + 1);
   logic [SW_W-1:0]           SW;
   logic                      data_update;
   logic [CHANNELS*WIDTH-1:0] data_in;
   logic [CHANNELS*WIDTH-1:0] filter_out;
   logic                      out_valid;
   logic                      overrun;
   modport master (output SW, data_update, data_in, input filter_out, out_valid, overrun);
   modport slave  (input SW, data_update, data_in, output filter_out, out_valid, overrun);
endinterface

// File: rtl/moving_average_filter.sv
// moving_average_filter: per-channel boxcar average over 2^SW samples.
// MAF_PRIME_EN: first sample after reset or flush fills the whole window.
module moving_average_filter #(
   parameter int WIDTH         = 16,
   parameter int CHANNELS      = 2,
   parameter int LOG_DEPTH_MAX = 3
) (
   input logic                    CLOCK_50,
   input logic                    reset_n,
   moving_average_filter_if.slave bus
);
   localparam int SW_W = $clog2(LOG_DEPTH_MAX + 1);
   localparam int S    = WIDTH + LOG_DEPTH_MAX;
   localparam int CW   = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   localparam int N    = 1 << LOG_DEPTH_MAX;
   typedef enum logic [1:0] {IDLE, CAPTURE, CALC, DONE} state_t;
   state_t                    state_q, state_d;
   logic [2:0]                sync_q, sync_d;
   logic [CW-1:0]             ch_q, ch_d;
   logic [LOG_DEPTH_MAX-1:0]  wr_ptr_q, wr_ptr_d, rd_idx;
   logic [SW_W-1:0]           sw_q, sw_d, sh;
   logic [CHANNELS*WIDTH-1:0] data_q, data_d, out_q, out_d;
   logic signed [S-1:0]       sum_q [CHANNELS];
   logic signed [S-1:0]       sum_d [CHANNELS];
   logic [WIDTH-1:0]          buf_q [CHANNELS][N];
   logic [WIDTH-1:0]          buf_d [CHANNELS][N];
   logic                      out_valid_q, out_valid_d, overrun_q, overrun_d;
   logic                      evt, prime;
   logic [WIDTH-1:0]          new_s, old_s;
   logic signed [S-1:0]       new_x, old_x;
`ifdef MAF_PRIME_EN
   logic empty_q, empty_d;
   assign prime = empty_q;
`else
   assign prime = 1'b0;
`endif
   assign evt   = sync_q[1] & ~sync_q[2];
   assign sh    = sw_q > SW_W'(LOG_DEPTH_MAX) ? SW_W'(LOG_DEPTH_MAX) : sw_q;
   // Slot written D samples ago; for D = 2^LOG_DEPTH_MAX this is the slot about to be overwritten.
   assign rd_idx = wr_ptr_q - LOG_DEPTH_MAX'(1 << sh);
   assign new_s  = data_q[int'(ch_q)*WIDTH +: WIDTH];
   assign old_s  = buf_q[ch_q][rd_idx];
   assign new_x  = {{LOG_DEPTH_MAX{new_s[WIDTH-1]}}, new_s};
   assign old_x  = {{LOG_DEPTH_MAX{old_s[WIDTH-1]}}, old_s};
   assign bus.filter_out = out_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.overrun    = overrun_q;
   always_comb begin
      state_d     = state_q;
      sync_d      = {sync_q[1:0], bus.data_update};
      ch_d        = ch_q;
      wr_ptr_d    = wr_ptr_q;
      sw_d        = sw_q;
      data_d      = data_q;
      out_d       = out_q;
      sum_d       = sum_q;
      buf_d       = buf_q;
      out_valid_d = 1'b0;
      overrun_d   = evt && state_q != IDLE;
`ifdef MAF_PRIME_EN
      empty_d     = empty_q;
`endif
      case (state_q)
         IDLE: state_d = evt ? CAPTURE : IDLE;
         CAPTURE: begin
            data_d  = bus.data_in;
            sw_d    = bus.SW;
            ch_d    = '0;
            state_d = CALC;
            if (bus.SW != sw_q) begin
               sum_d    = '{default: '0};
               buf_d    = '{default: '0};
               wr_ptr_d = '0;
`ifdef MAF_PRIME_EN
               empty_d  = 1'b1;
`endif
            end
         end
         CALC: begin
            if (prime) begin
               sum_d[ch_q] = new_x <<< sh;
               for (int i = 0; i < N; i++) buf_d[ch_q][i] = new_s;
            end else begin
               sum_d[ch_q] = sum_q[ch_q] + new_x - old_x;
               buf_d[ch_q][wr_ptr_q] = new_s;
            end
            ch_d    = ch_q + 1'b1;
            state_d = ch_q == CW'(CHANNELS - 1) ? DONE : CALC;
         end
         default: begin
            for (int k = 0; k < CHANNELS; k++) out_d[k*WIDTH +: WIDTH] = WIDTH'(sum_q[k] >>> sh);
            out_valid_d = 1'b1;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            state_d     = IDLE;
`ifdef MAF_PRIME_EN
            empty_d     = 1'b0;
`endif
         end
      endcase
   end
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         sync_q      <= '0;
         ch_q        <= '0;
         wr_ptr_q    <= '0;
         sw_q        <= '0;
         data_q      <= '0;
         out_q       <= '0;
         sum_q       <= '{default: '0};
         buf_q       <= '{default: '0};
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef MAF_PRIME_EN
         empty_q     <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         ch_q        <= ch_d;
         wr_ptr_q    <= wr_ptr_d;
         sw_q        <= sw_d;
         data_q      <= data_d;
         out_q       <= out_d;
         sum_q       <= sum_d;
         buf_q       <= buf_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
`ifdef MAF_PRIME_EN
         empty_q     <= empty_d;
`endif
      end
   end
endmodule

// File: tb/tb_moving_average_filter.sv
// tb_moving_average_filter: directed samples with a queue-based scoreboard on out_valid.
module tb_moving_average_filter;
   localparam int W = 16, CH = 2, L = 3;
`ifdef MAF_PRIME_EN
   localparam bit PRIME = 1'b1;
`else
   localparam bit PRIME = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int checks = 0, errors = 0, ov_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;
   always #5 clk = ~clk;
   moving_average_filter_if #(.WIDTH(W), .CHANNELS(CH), .LOG_DEPTH_MAX(L)) bus ();
   moving_average_filter #(.WIDTH(W), .CHANNELS(CH), .LOG_DEPTH_MAX(L)) dut (
      .CLOCK_50(clk),
      .reset_n (reset_n),
      .bus     (bus)
   );
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   // Monitor: every out_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset_n && bus.overrun) ov_cnt++;
      if (reset_n && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got x=%0d y=%0d expected no output",
                     $signed(bus.filter_out[15:0]), $signed(bus.filter_out[31:16]));
         end else begin
            e = exp_q.pop_front();
            chk("filter_x", $signed(bus.filter_out[15:0]), $signed(e[15:0]));
            chk("filter_y", $signed(bus.filter_out[31:16]), $signed(e[31:16]));
         end
      end
   end
   task automatic send(input logic [1:0] sw, input int x, input int y, input int ex, input int ey);
      int lat;
      bus.SW      = sw;
      bus.data_in = {16'(y), 16'(x)};
      exp_q.push_back({16'(ey), 16'(ex)});
      @(negedge clk);
      bus.data_update = 1'b1;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", lat - 1, CH + 4);
      @(negedge clk);
      bus.data_update = 1'b0;
      repeat (3) @(posedge clk);
   endtask
   initial begin
      bus.SW          = '0;
      bus.data_update = 1'b0;
      bus.data_in     = '0;
      #12;
      chk("reset_filter_out", int'(bus.filter_out), 0);
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_overrun", int'(bus.overrun), 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      send(0, 10, 1, 10, 1);
      send(2, 8, -8, PRIME ? 8 : 2, PRIME ? -8 : -2);
      send(2, 8, -8, PRIME ? 8 : 4, PRIME ? -8 : -4);
      send(2, 8, -8, PRIME ? 8 : 6, PRIME ? -8 : -6);
      send(2, 8, -8, 8, -8);
      send(2, 0, 0, 6, -6);
      send(1, -16, 3, PRIME ? -16 : -8, PRIME ? 3 : 1);
      send(1, 6, 5, -5, 4);
      send(3, 24, -24, PRIME ? 24 : 3, PRIME ? -24 : -3);
      send(0, -32768, 32767, -32768, 32767);
      send(1, -32768, 32767, PRIME ? -32768 : -16384, PRIME ? 32767 : 16383);
      send(1, -32768, 32767, -32768, 32767);
      chk("no_overrun_yet", ov_cnt, 0);
      // Second strobe edge lands while the first sample is still being processed.
      bus.SW      = 2'd1;
      bus.data_in = {16'(4), 16'(2)};
      exp_q.push_back({16'(16385), 16'(-16383)});
      @(negedge clk);
      bus.data_update = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.data_update = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.data_update = 1'b1;
      bus.data_in     = {16'(999), 16'(999)};
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.data_update = 1'b0;
      repeat (6) @(posedge clk);
      chk("overrun_pulses", ov_cnt, 1);
      chk("pending_after_overrun", exp_q.size(), 0);
      send(1, 2, 4, 2, 4);
      bus.data_in = {16'(100), 16'(100)};
      @(negedge clk);
      bus.data_update = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      reset_n         = 1'b0;
      bus.data_update = 1'b0;
      #1;
      chk("midcalc_filter_out", int'(bus.filter_out), 0);
      chk("midcalc_out_valid", int'(bus.out_valid), 0);
      chk("midcalc_overrun", int'(bus.overrun), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(posedge clk);
      chk("pending_after_reset", exp_q.size(), 0);
      send(0, 7, -7, 7, -7);
      repeat (5) @(posedge clk);
      chk("pending_at_end", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/moving_average_filter.md
MOVING_AVERAGE_FILTER -- requirements
Module: moving_average_filter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16: sample width in bits, signed two's complement.
REQ-002 The module SHALL have parameter CHANNELS, default 2: number of independent filtered channels (x, y, ...).
REQ-003 The module SHALL have parameter LOG_DEPTH_MAX, default 3: window storage per channel is 2^LOG_DEPTH_MAX samples.
REQ-004 Port CLOCK_50  input  1: the single clock; all state changes on its rising edge.
REQ-005 Port reset_n  input  1: asynchronous, active-low reset.
REQ-006 Port SW  input  LOG_DEPTH_MAX (clog2-sized): mode, window depth D = 2^SW, clamped to 2^LOG_DEPTH_MAX.
REQ-007 Port data_update  input  1: new-sample strobe, asynchronous to CLOCK_50; each rising edge is one sample event.
REQ-008 Port data_in  input  CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port filter_out  output  CHANNELS*WIDTH: filtered samples, same packing as data_in.
REQ-010 Port out_valid  output  1: one-cycle pulse when filter_out has been updated.
REQ-011 Port overrun  output  1: one-cycle pulse when a sample event is dropped.

Function
REQ-012 data_update SHALL pass through a 2-flop synchroniser; a sample event is the synchronised level going 0->1.
REQ-013 FSM states SHALL be IDLE, CAPTURE, CALC, DONE; IDLE->CAPTURE on sample event.
REQ-014 CAPTURE SHALL register data_in and SW for all channels in one cycle; SW is never sampled elsewhere.
REQ-015 CALC SHALL process one channel per cycle (channel counter 0..CHANNELS-1), then go to DONE.
REQ-016 Per channel in CALC: sum <= sum + new - buf[wr_ptr - D] (modulo window size); buf[wr_ptr] <= new.
REQ-017 Running sum SHALL be signed WIDTH+LOG_DEPTH_MAX bits; no overflow possible, no saturation.
REQ-018 Output SHALL be sum arithmetically shifted right by log2(D) (rounds toward minus infinity), truncated to WIDTH.
REQ-019 DONE SHALL assert out_valid for exactly one cycle, then return to IDLE; shared wr_ptr increments, wrapping 2^LOG_DEPTH_MAX-1 -> 0.
REQ-020 Latency: out_valid SHALL go high exactly CHANNELS+4 cycles after the first CLOCK_50 edge sampling data_update high.
REQ-021 filter_out SHALL be stable between out_valid pulses; all channels update within the same CALC pass.
REQ-022 A sample event arriving while not in IDLE SHALL be dropped and SHALL pulse overrun once.
REQ-023 If captured SW differs from SW of the previous accepted sample, the window SHALL flush before processing: buffers and sums cleared, wr_ptr reset to 0.
REQ-024 SW = 0 (D = 1) SHALL give filter_out equal to data_in of the same event.
REQ-025 Most-negative input (e.g. 16'h8000) SHALL be filtered without overflow; sample = -32768 in all slots gives output -32768.

Reset
REQ-026 On reset_n low, immediately: FSM to IDLE, filter_out = 0, out_valid = 0, overrun = 0, sums, buffers, wr_ptr, synchroniser and stored SW = 0.
REQ-027 Reset asserted mid-CALC SHALL abandon the pass; no out_valid follows reset release until a new sample event.

Configuration
REQ-028 Macro MAF_PRIME_EN: when defined, the first sample after reset or flush SHALL fill all D window slots (sum = D*sample), so output equals that sample immediately.
REQ-029 Without MAF_PRIME_EN, the window SHALL start zero-filled and output ramps up over D samples.

Verification
REQ-030 SW=0, x=10, y=1 -> out_valid after CHANNELS+4 cycles, filter_out x=10, y=1.
REQ-031 No prime, SW=2 (D=4), x sequence 8,8,8,8 -> outputs 2,4,6,8; fifth sample 0 -> 6.
REQ-032 MAF_PRIME_EN, SW=1, x=16'hfff0 (-16) then 6 -> outputs -16, -5 (floor of -10/2).
REQ-033 SW 1->3 between samples -> flush; next sample 24 gives 3 (no prime) or 24 (prime).
REQ-034 Second data_update edge during CALC -> overrun pulse once, only one out_valid, sums unchanged by dropped sample.
REQ-035 reset_n low during CALC -> all outputs 0 asynchronously, no out_valid after release.
